// File: rtl/mips_fetch_pkg.sv
// Shared types for the mini MIPS instruction-fetch unit.
// Prefetch entries pair each instruction with the PC it came from.
package mips_fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH,
    STOPPED
  } fetch_state_t;

endpackage

// File: rtl/mips_prefetch_fifo.sv
// Small synchronous FIFO of fetch entries between fetch and decode.
// flush empties it in one cycle and wins over a same-cycle push.
module mips_prefetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;
  fetch_entry_t  mem_q [DEPTH];

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch initiator: owns the PC, reads memory combinationally
// and buffers {pc, instr} pairs for decode; supports redirect and stop.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int                DEPTH     = 2,
  parameter int                MEM_WORDS = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   read_address,
  input  logic [INSTR_W-1:0]  instruction,
  output logic [INSTR_W-1:0]  instr_out,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                fetch_done
);

  localparam int                CW    = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] MEM_W = ADDR_W'(MEM_WORDS);
  localparam fetch_state_t      RST_ST =
    (RESET_PC >= MEM_W) ? STOPPED : FETCH;

  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_state_t      state_q, state_d;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  assign pop         = ~empty & instr_ready;
  assign push        = ~redirect_valid & (pc_q < MEM_W) & (~full | pop);
  assign instr_valid = (count != '0);
  assign read_address = pc_q;
  assign fetch_done  = (state_q == STOPPED);
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;
  assign wr_entry    = '{pc: pc_q, instr: instruction};

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    unique case (1'b1)
      redirect_valid: begin
        pc_d    = redirect_pc;
        state_d = (redirect_pc >= MEM_W) ? STOPPED : FETCH;
      end
      push: begin
        pc_d = pc_q + 32'd1;
        if (pc_q + 32'd1 == MEM_W) state_d = STOPPED;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RST_ST;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  mips_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (wr_entry),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios plus random traffic
// against a queue-based model of the delivered instruction stream.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] read_address;
  logic [15:0] instruction;
  logic [15:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_done;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  assign instruction = (read_address < 32'd16) ?
    16'h1000 + read_address[15:0] : 16'hdead;

  mips_fetch_unit #(
    .DEPTH     (2),
    .MEM_WORDS (16),
    .RESET_PC  (32'd0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .read_address   (read_address),
    .instruction    (instruction),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_done     (fetch_done)
  );

  // Drive one cycle of inputs, advance the model, land on next negedge.
  task automatic cycle(input logic rst, input logic rdy,
                       input logic rv, input logic [31:0] rpc);
    logic [31:0] dummy;
    reset = rst;
    instr_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    if (rst) begin
      m_pc = 32'd0;
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && rdy) dummy = m_q.pop_front();
      if (rv) begin
        m_pc = rpc;
        m_q.delete();
      end else if (m_pc < 32'd16 && m_q.size() < 2) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    compared++;
    if (instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_valid: got %0b want 0", instr_valid);
    end
    compared++;
    if (read_address !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_addr: got %0h want 0", read_address);
    end
    compared++;
    if (fetch_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_done: got %0b want 0", fetch_done);
    end
  endtask

  task automatic test_stream();
    int n = 0;
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    compared++;
    if (instr_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL stream_latency: got %0b want 1", instr_valid);
    end
    for (int i = 0; i < 30; i++) begin
      if (instr_valid === 1'b1) begin
        compared++;
        if (instr_pc !== 32'(n) || instr_out !== 16'(16'h1000 + n)) begin
          mismatched++;
          $display("FAIL stream_seq: got pc %0d instr %h want pc %0d instr %h",
                   instr_pc, instr_out, n, 16'(16'h1000 + n));
        end
        n++;
      end
      cycle(0, 1, 0, 0);
    end
    compared++;
    if (n != 16) begin
      mismatched++;
      $display("FAIL stream_count: got %0d want 16", n);
    end
    compared++;
    if (fetch_done !== 1'b1 || read_address !== 32'd16) begin
      mismatched++;
      $display("FAIL stream_done: got done %0b addr %0d want 1 16",
               fetch_done, read_address);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    compared++;
    if (read_address !== 32'd2 || instr_valid !== 1'b1 || instr_pc !== 32'd0) begin
      mismatched++;
      $display("FAIL stall_fill: got addr %0d valid %0b pc %0d want 2 1 0",
               read_address, instr_valid, instr_pc);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0);
      compared++;
      if (instr_out !== 16'h1000 || read_address !== 32'd2) begin
        mismatched++;
        $display("FAIL stall_hold: got instr %h addr %0d want 1000 2",
                 instr_out, read_address);
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (instr_valid === 1'b1) begin
        compared++;
        if (instr_pc !== 32'(n)) begin
          mismatched++;
          $display("FAIL stall_resume: got %0d want %0d", instr_pc, n);
        end
        n++;
      end
      cycle(0, 1, 0, 0);
    end
    compared++;
    if (n != 6) begin
      mismatched++;
      $display("FAIL stall_gapless: got %0d want 6", n);
    end
  endtask

  task automatic test_redirect_flush();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    compared++;
    if (instr_pc !== 32'd3 || read_address !== 32'd5) begin
      mismatched++;
      $display("FAIL flush_setup: got pc %0d addr %0d want 3 5",
               instr_pc, read_address);
    end
    cycle(0, 0, 1, 32'd9);
    compared++;
    if (instr_valid !== 1'b0 || read_address !== 32'd9) begin
      mismatched++;
      $display("FAIL flush_drop: got valid %0b addr %0d want 0 9",
               instr_valid, read_address);
    end
    cycle(0, 0, 0, 0);
    compared++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd9 || instr_out !== 16'h1009) begin
      mismatched++;
      $display("FAIL flush_target: got valid %0b pc %0d instr %h want 1 9 1009",
               instr_valid, instr_pc, instr_out);
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (instr_pc !== 32'(9 + i)) begin
        mismatched++;
        $display("FAIL flush_seq: got %0d want %0d", instr_pc, 9 + i);
      end
      cycle(0, 1, 0, 0);
    end
  endtask

  task automatic test_redirect_pop();
    int n = 12;
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (instr_valid === 1'b1 && instr_pc === 32'd5) break;
      cycle(0, 1, 0, 0);
    end
    compared++;
    if (instr_pc !== 32'd5) begin
      mismatched++;
      $display("FAIL rpop_head: got %0d want 5", instr_pc);
    end
    cycle(0, 1, 1, 32'd12);
    compared++;
    if (instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rpop_flush: got %0b want 0", instr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      if (instr_valid === 1'b1) begin
        compared++;
        if (instr_pc !== 32'(n)) begin
          mismatched++;
          $display("FAIL rpop_seq: got %0d want %0d", instr_pc, n);
        end
        n++;
      end
      cycle(0, 1, 0, 0);
    end
    compared++;
    if (n != 15) begin
      mismatched++;
      $display("FAIL rpop_count: got %0d want 15", n);
    end
  endtask

  task automatic test_out_of_range();
    cycle(0, 1, 1, 32'd20);
    compared++;
    if (fetch_done !== 1'b1 || instr_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL oor_done: got done %0b valid %0b want 1 0",
               fetch_done, instr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0);
      compared++;
      if (instr_valid !== 1'b0 || fetch_done !== 1'b1 || read_address !== 32'd20) begin
        mismatched++;
        $display("FAIL oor_idle: got valid %0b done %0b addr %0d want 0 1 20",
                 instr_valid, fetch_done, read_address);
      end
    end
    cycle(0, 1, 1, 32'd2);
    compared++;
    if (fetch_done !== 1'b0) begin
      mismatched++;
      $display("FAIL oor_restart_done: got %0b want 0", fetch_done);
    end
    cycle(0, 1, 0, 0);
    compared++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd2) begin
      mismatched++;
      $display("FAIL oor_restart: got valid %0b pc %0d want 1 2",
               instr_valid, instr_pc);
    end
  endtask

  task automatic test_reset_midstream();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    compared++;
    if (instr_valid !== 1'b1 || read_address !== 32'd2) begin
      mismatched++;
      $display("FAIL mid_full: got valid %0b addr %0d want 1 2",
               instr_valid, read_address);
    end
    cycle(1, 0, 1, 32'd7);
    compared++;
    if (instr_valid !== 1'b0 || read_address !== 32'd0 || fetch_done !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: got valid %0b addr %0d done %0b want 0 0 0",
               instr_valid, read_address, fetch_done);
    end
    cycle(0, 1, 0, 0);
    compared++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd0) begin
      mismatched++;
      $display("FAIL mid_restart: got valid %0b pc %0d want 1 0",
               instr_valid, instr_pc);
    end
  endtask

  task automatic test_random();
    logic        rst, rdy, rv;
    logic [31:0] rpc;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      compared++;
      if (instr_valid !== (m_q.size() != 0)) begin
        mismatched++;
        $display("FAIL rnd_valid: cyc %0d got %0b want %0b",
                 i, instr_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        compared++;
        if (instr_pc !== m_q[0] || instr_out !== 16'(16'h1000 + m_q[0][15:0])) begin
          mismatched++;
          $display("FAIL rnd_head: cyc %0d got pc %0d instr %h want pc %0d",
                   i, instr_pc, instr_out, m_q[0]);
        end
      end
      compared++;
      if (read_address !== m_pc || fetch_done !== (m_pc >= 32'd16)) begin
        mismatched++;
        $display("FAIL rnd_pc: cyc %0d got addr %0d done %0b want %0d %0b",
                 i, read_address, fetch_done, m_pc, m_pc >= 32'd16);
      end
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 14) == 0);
      rpc = 32'($urandom_range(0, 20));
      cycle(rst, rdy, rv, rpc);
    end
  endtask

  initial begin
    m_pc = 32'd0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_pop();
    test_out_of_range();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
